// File: rtl/ncl_dr_tx.sv
// Clocked-to-NCL dual-rail transmitter: alternates DATA/NULL wavefronts under the ki handshake.
// Optional watchdog enabled by defining NCL_TX_TIMEOUT_EN.
module ncl_dr_tx #(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             ki,
    output logic [WIDTH-1:0] rail1,
    output logic [WIDTH-1:0] rail0,
    output logic             busy,
    output logic [15:0]      tx_count,
    output logic             timeout_err
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_NULL} state_t;

    state_t           state, state_nxt;
    logic             ki_meta;
    logic             rdy_en;
    logic [AW:0]      wr_ptr, rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             full, empty, push, pop, drop, done;

    // First synchronizer stage; the state and rail flops act as the second stage,
    // so the rails move on the same edge that a conventional ki_s would update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ki_meta <= 1'b0;
            rdy_en  <= 1'b0;
        end else begin
            ki_meta <= ki;
            rdy_en  <= 1'b1;
        end
    end

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign in_ready = rdy_en & ~full;
    assign push     = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= in_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (!empty && ki_meta) state_nxt = S_DATA;
            S_DATA:  if (!ki_meta)          state_nxt = S_NULL;
            S_NULL:  if (ki_meta)           state_nxt = S_IDLE;
            default:                        state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        pop  = (state == S_IDLE) && (state_nxt == S_DATA);
        drop = (state == S_DATA) && (state_nxt == S_NULL);
        done = (state == S_NULL) && (state_nxt == S_IDLE);
    end

    // Rails come straight from flops; DATA is loaded from the FIFO head on the pop edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rail1    <= '0;
            rail0    <= '0;
            tx_count <= '0;
        end else begin
            if (pop) begin
                rail1 <= mem[rd_ptr[AW-1:0]];
                rail0 <= ~mem[rd_ptr[AW-1:0]];
            end else if (drop) begin
                rail1 <= '0;
                rail0 <= '0;
            end
            if (done) tx_count <= tx_count + 16'd1;
        end
    end

    assign busy = !empty || (state != S_IDLE);

`ifdef NCL_TX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] wd_cnt;
    logic          wd_err;

    // Counts cycles spent waiting on ki; saturates and leaves the FSM untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt <= '0;
            wd_err <= 1'b0;
        end else if (state_nxt != state) begin
            wd_cnt <= '0;
        end else if ((state != S_IDLE) && (wd_cnt != TW'(TIMEOUT))) begin
            wd_cnt <= wd_cnt + 1'b1;
            if (wd_cnt == TW'(TIMEOUT - 1)) wd_err <= 1'b1;
        end
    end

    assign timeout_err = wd_err;
`else
    logic unused_timeout;
    assign unused_timeout = |TIMEOUT;
    assign timeout_err    = 1'b0;
`endif

endmodule
